// File: rtl/memory_pkg.sv
// Shared memory-subsystem types and widths used by the single-port arbiter.
package memory_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority decision between fetch and load/store, plus the starvation streak
// counter that forces a fetch grant after STARVE_LIM consecutive LS wins.
module mem_arb_prio
    import memory_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       decide_i,
    input  logic       if_req_i,
    input  logic       ls_req_i,
    output logic       win_valid_o,
    output arb_owner_e winner_o
);

    localparam int          SW  = $clog2(STARVE_LIM + 2);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    // Load/store wins by default unless fetch has already waited through LIM LS grants.
    always_comb begin
        win_valid_o = if_req_i | ls_req_i;
        winner_o    = OWN_IF;
        if (ls_req_i && !(if_req_i && (streak_q == LIM))) begin
            winner_o = OWN_LS;
        end
    end

    // Streak only moves on a decision cycle: counts LS wins that bypassed a waiting fetch.
    always_comb begin
        streak_d = streak_q;
        if (decide_i) begin
            if (!if_req_i || (winner_o == OWN_IF)) begin
                streak_d = '0;
            end else if (streak_q != LIM) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction outstanding at a time: IDLE picks a winner, ISSUE presents
// it to memory until accepted, WAIT routes the single response back.
// Optional stall counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import memory_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_WIDTH,
    parameter int DATA_W     = MEM_DATA_WIDTH,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         if_stall_cnt,
    output logic [31:0]         ls_stall_cnt
`endif
);

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

    logic       win_valid;
    arb_owner_e winner;
    logic       issue;
    logic       route_rsp;

    mem_arb_prio #(
        .STARVE_LIM (STARVE_LIM)
    ) u_prio (
        .clk         (clk),
        .rstn        (rstn),
        .decide_i    (state_q == IDLE),
        .if_req_i    (if_req),
        .ls_req_i    (ls_req),
        .win_valid_o (win_valid),
        .winner_o    (winner)
    );

    // Next-state: latch the winner in IDLE, hold owner until memory accepts and responds.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory request mux and handshake routing; everything idles at zero outside ISSUE/WAIT.
    always_comb begin
        issue     = (state_q == ISSUE);
        route_rsp = (state_q == WAIT) && mem_rvalid;
        mem_req   = issue;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            if (owner_q == OWN_LS) begin
                mem_we    = ls_we;
                mem_be    = ls_be;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
            end else begin
                mem_be    = '1;
                mem_addr  = if_addr;
            end
        end
        if_gnt    = issue && mem_gnt && (owner_q == OWN_IF);
        ls_gnt    = issue && mem_gnt && (owner_q == OWN_LS);
        if_rvalid = route_rsp && (owner_q == OWN_IF);
        ls_rvalid = route_rsp && (owner_q == OWN_LS);
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        ls_rdata  = ls_rvalid ? mem_rdata : ls_rdata_q;
    end

    // State, owner and held read data; read data only changes on a routed response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (ls_rvalid) begin
                ls_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] if_stall_q, ls_stall_q;

    // Stall counters: cycles a requester is asking but not being accepted, wrapping freely.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_stall_q <= '0;
            ls_stall_q <= '0;
        end else begin
            if_stall_q <= if_stall_q + 32'(if_req && !if_gnt);
            ls_stall_q <= ls_stall_q + 32'(ls_req && !ls_gnt);
        end
    end

    assign if_stall_cnt = if_stall_q;
    assign ls_stall_cnt = ls_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory model answers the
// arbiter, expected responses are queued as requests are driven and popped
// when either rvalid fires. Stall counters are exercised when
// MEM_ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;
    import memory_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_LIM = 4;

    logic clk = 1'b0;
    logic rstn;
    logic if_req, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [DATA_W/8-1:0] ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata, ls_rdata;
    logic mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [DATA_W/8-1:0] mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt, ls_stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        , .if_stall_cnt(if_stall_cnt), .ls_stall_cnt(ls_stall_cnt)
`endif
    );

    typedef struct {
        logic        isLs;
        logic [31:0] data;
    } rsp_t;

    int compared   = 0;
    int mismatched = 0;
    rsp_t expQ[$];

    logic [31:0] memArr [logic [31:0]];
    bit          modelEn  = 1'b1;
    int          gntStall = 0;
    int          issueCnt = 0;
    bit          pending  = 1'b0;
    logic [31:0] respData = '0;

    function automatic logic [31:0] readMem(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] writeResp(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic rsp_t mkRsp(input logic isLs, input logic [31:0] data);
        rsp_t r;
        r.isLs = isLs;
        r.data = data;
        return r;
    endfunction

    // Memory model, drive side: grant after gntStall ISSUE cycles, answer the cycle after.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h5555_AAAA;
        forever begin
            @(posedge clk);
            #1;
            if (modelEn) begin
                mem_rvalid = pending;
                mem_rdata  = pending ? respData : 32'h5555_AAAA;
                pending    = 1'b0;
                if (mem_req) begin
                    if (issueCnt >= gntStall) begin
                        mem_gnt  = 1'b1;
                        issueCnt = 0;
                    end else begin
                        mem_gnt  = 1'b0;
                        issueCnt++;
                    end
                end else begin
                    mem_gnt = 1'b0;
                end
            end
        end
    end

    // Memory model, accept side: capture the accepted request and perform writes.
    initial begin
        logic [31:0] word;
        forever begin
            @(negedge clk);
            if (modelEn && mem_req && mem_gnt) begin
                pending = 1'b1;
                if (mem_we) begin
                    respData = writeResp(mem_addr);
                    word = readMem(mem_addr);
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    memArr[mem_addr] = word;
                end else begin
                    respData = readMem(mem_addr);
                end
            end
        end
    end

    // Scoreboard: every routed response must match the oldest queued expectation.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (if_rvalid === 1'b1 || ls_rvalid === 1'b1) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_rvalid: got if_rvalid=%b ls_rvalid=%b, wanted none", if_rvalid, ls_rvalid);
                end else begin
                    e = expQ.pop_front();
                    if (if_rvalid !== !e.isLs || ls_rvalid !== e.isLs ||
                        (e.isLs ? ls_rdata : if_rdata) !== e.data) begin
                        mismatched++;
                        $display("[TB] FAIL rsp_route: got if=%b ls=%b if_rdata=%h ls_rdata=%h, wanted isLs=%b data=%h",
                                 if_rvalid, ls_rvalid, if_rdata, ls_rdata, e.isLs, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitGnt(input bit isLs, input int maxCyc, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < maxCyc && !ok; n++) begin
            @(negedge clk);
            if ((isLs ? ls_gnt : if_gnt) === 1'b1) ok = 1'b1;
            else nextCycle();
        end
    endtask

    task automatic waitQueueEmpty(input int maxCyc, output bit ok);
        int n = 0;
        while (expQ.size() != 0 && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        ok = (expQ.size() == 0);
        nextCycle();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({mem_req, mem_we, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b, wanted 000000", {mem_req, mem_we, if_gnt, ls_gnt, if_rvalid, ls_rvalid});
        end
        compared++;
        if (mem_addr !== 0 || mem_wdata !== 0 || mem_be !== 0) begin
            mismatched++;
            $display("[TB] FAIL reset_mem_bus: got addr=%h wdata=%h be=%h, wanted zeros", mem_addr, mem_wdata, mem_be);
        end
        compared++;
        if (if_rdata !== 0 || ls_rdata !== 0) begin
            mismatched++;
            $display("[TB] FAIL reset_rdata: got if=%h ls=%h, wanted 0", if_rdata, ls_rdata);
        end
        nextCycle();
        rstn = 1'b1;
        nextCycle();
    endtask

    task automatic test_if_only();
        bit lsSeen = 1'b0;
        bit ok;
        memArr[32'h100] = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h100;
        expQ.push_back(mkRsp(1'b0, 32'hDEAD_BEEF));
        @(negedge clk);
        lsSeen |= ls_rvalid;
        compared++;
        if (if_gnt !== 1'b0 || mem_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL if_only_cycle0: got gnt=%b mem_req=%b, wanted 0 0", if_gnt, mem_req);
        end
        nextCycle();
        @(negedge clk);
        lsSeen |= ls_rvalid;
        compared++;
        if (if_gnt !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
            mismatched++;
            $display("[TB] FAIL if_only_issue: got gnt=%b req=%b addr=%h we=%b be=%h, wanted 1 1 100 0 f",
                     if_gnt, mem_req, mem_addr, mem_we, mem_be);
        end
        nextCycle();
        if_req = 1'b0;
        @(negedge clk);
        lsSeen |= ls_rvalid;
        compared++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("[TB] FAIL if_only_rvalid: got rvalid=%b rdata=%h, wanted 1 deadbeef", if_rvalid, if_rdata);
        end
        nextCycle();
        @(negedge clk);
        lsSeen |= ls_rvalid;
        compared++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("[TB] FAIL if_only_hold: got rvalid=%b rdata=%h, wanted 0 deadbeef", if_rvalid, if_rdata);
        end
        compared++;
        if (lsSeen !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL if_only_ls_quiet: got ls_rvalid seen=%b, wanted 0", lsSeen);
        end
        waitQueueEmpty(10, ok);
    endtask

    task automatic test_both();
        bit ok;
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h200; ls_wdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h100;
        expQ.push_back(mkRsp(1'b1, writeResp(32'h200)));
        expQ.push_back(mkRsp(1'b0, 32'hDEAD_BEEF));
        nextCycle();
        @(negedge clk);
        compared++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
            mem_wdata !== 32'h1234_5678 || mem_be !== 4'hF) begin
            mismatched++;
            $display("[TB] FAIL both_ls_first: got ls_gnt=%b if_gnt=%b we=%b addr=%h wdata=%h be=%h, wanted 1 0 1 200 12345678 f",
                     ls_gnt, if_gnt, mem_we, mem_addr, mem_wdata, mem_be);
        end
        nextCycle();
        ls_req = 1'b0;
        waitGnt(1'b0, 10, ok);
        compared++;
        if (ok !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            mismatched++;
            $display("[TB] FAIL both_if_second: got ok=%b we=%b addr=%h, wanted 1 0 100", ok, mem_we, mem_addr);
        end
        nextCycle();
        if_req = 1'b0;
        waitQueueEmpty(10, ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL both_drain: got pending=%0d, wanted 0", expQ.size());
        end
    endtask

    task automatic test_readback();
        bit ok;
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h3; ls_addr = 32'h200; ls_wdata = 32'hAAAA_BBBB;
        expQ.push_back(mkRsp(1'b1, writeResp(32'h200)));
        waitGnt(1'b1, 10, ok);
        compared++;
        if (ok !== 1'b1 || mem_be !== 4'h3 || mem_wdata !== 32'hAAAA_BBBB) begin
            mismatched++;
            $display("[TB] FAIL readback_write: got ok=%b be=%h wdata=%h, wanted 1 3 aaaabbbb", ok, mem_be, mem_wdata);
        end
        nextCycle();
        ls_we = 1'b0; ls_be = 4'hF;
        expQ.push_back(mkRsp(1'b1, 32'h1234_BBBB));
        waitGnt(1'b1, 10, ok);
        nextCycle();
        ls_req = 1'b0;
        waitQueueEmpty(10, ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL readback_drain: got pending=%0d, wanted 0", expQ.size());
        end
    endtask

    task automatic test_starvation();
        logic expSeq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        logic obsSeq [10];
        int   nGnt = 0;
        bit   ok;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h104;
        for (int i = 0; i < 10; i++) begin
            expQ.push_back(mkRsp(expSeq[i], expSeq[i] ? readMem(32'h300) : readMem(32'h104)));
        end
        for (int n = 0; n < 80 && nGnt < 10; n++) begin
            @(negedge clk);
            if (ls_gnt === 1'b1 || if_gnt === 1'b1) begin
                obsSeq[nGnt] = ls_gnt;
                nGnt++;
            end
            nextCycle();
        end
        ls_req = 1'b0; if_req = 1'b0;
        compared++;
        if (nGnt != 10) begin
            mismatched++;
            $display("[TB] FAIL starve_count: got %0d grants, wanted 10", nGnt);
        end
        for (int i = 0; i < nGnt; i++) begin
            compared++;
            if (obsSeq[i] !== expSeq[i]) begin
                mismatched++;
                $display("[TB] FAIL starve_seq[%0d]: got ls=%b, wanted ls=%b", i, obsSeq[i], expSeq[i]);
            end
        end
        waitQueueEmpty(20, ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL starve_drain: got pending=%0d, wanted 0", expQ.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        gntStall = 5;
        if_req = 1'b1; if_addr = 32'h108;
        expQ.push_back(mkRsp(1'b0, readMem(32'h108)));
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            if (k == 2) begin
                ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h30C;
                expQ.push_back(mkRsp(1'b1, readMem(32'h30C)));
            end
            @(negedge clk);
            compared++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h108 || if_gnt !== (k == 6) || ls_gnt !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL stall_cycle%0d: got req=%b addr=%h if_gnt=%b ls_gnt=%b, wanted 1 108 %b 0",
                         k, mem_req, mem_addr, if_gnt, ls_gnt, (k == 6));
            end
        end
        nextCycle();
        if_req = 1'b0;
        gntStall = 0;
        waitGnt(1'b1, 20, ok);
        nextCycle();
        ls_req = 1'b0;
        waitQueueEmpty(10, ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stall_drain: got pending=%0d, wanted 0", expQ.size());
        end
    endtask

    task automatic test_reset_mid();
        modelEn = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 32'h10C;
        nextCycle();
        mem_gnt = 1'b1;
        @(negedge clk);
        compared++;
        if (if_gnt !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_gnt: got %b, wanted 1", if_gnt);
        end
        nextCycle();
        mem_gnt = 1'b0; if_req = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        compared++;
        if ({mem_req, mem_we, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 6'b0 || mem_addr !== 0 ||
            if_rdata !== 0 || ls_rdata !== 0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_outputs: got ctrl=%b addr=%h if_rdata=%h ls_rdata=%h, wanted zeros",
                     {mem_req, mem_we, if_gnt, ls_gnt, if_rvalid, ls_rvalid}, mem_addr, if_rdata, ls_rdata);
        end
        nextCycle();
        rstn = 1'b1;
        nextCycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        compared++;
        if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || if_rdata !== 0 || ls_rdata !== 0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_stray: got if_rvalid=%b ls_rvalid=%b if_rdata=%h ls_rdata=%h, wanted 0 0 0 0",
                     if_rvalid, ls_rvalid, if_rdata, ls_rdata);
        end
        nextCycle();
        mem_rvalid = 1'b0;
        pending = 1'b0; issueCnt = 0;
        modelEn = 1'b1;
        nextCycle();
    endtask

`ifdef MEM_ARB_PERF_CNT_EN
    task automatic test_perf();
        logic [31:0] if0, ls0;
        int ifHigh = 0, lsHigh = 0;
        bit dropIf, dropLs, ok;
        gntStall = 8;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h310;
        expQ.push_back(mkRsp(1'b1, readMem(32'h310)));
        expQ.push_back(mkRsp(1'b0, readMem(32'h110)));
        @(negedge clk);
        if0 = if_stall_cnt; ls0 = ls_stall_cnt;
        for (int n = 0; n < 100 && (ls_req || if_req || n < 2); n++) begin
            if (n != 0) @(negedge clk);
            if (ls_req) lsHigh++;
            if (if_req) ifHigh++;
            dropLs = ls_gnt; dropIf = if_gnt;
            nextCycle();
            if (dropLs) ls_req = 1'b0;
            if (dropIf) if_req = 1'b0;
            if (n == 0) begin
                if_req = 1'b1; if_addr = 32'h110;
            end
        end
        @(negedge clk);
        compared++;
        if (if_stall_cnt - if0 !== 32'(ifHigh - 1)) begin
            mismatched++;
            $display("[TB] FAIL perf_if_stall: got %0d, wanted %0d", if_stall_cnt - if0, ifHigh - 1);
        end
        compared++;
        if (ls_stall_cnt - ls0 !== 32'(lsHigh - 1)) begin
            mismatched++;
            $display("[TB] FAIL perf_ls_stall: got %0d, wanted %0d", ls_stall_cnt - ls0, lsHigh - 1);
        end
        nextCycle();
        gntStall = 0;
        waitQueueEmpty(20, ok);
    endtask
`endif

    initial begin
        bit ok;
        test_reset();
        test_if_only();
        test_both();
        test_readback();
        test_starvation();
        test_stall();
        test_reset_mid();
`ifdef MEM_ARB_PERF_CNT_EN
        test_perf();
`endif
        waitQueueEmpty(20, ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL final_drain: got pending=%0d, wanted 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
